divider_arbiter: RTL

DIVIDER_ARBITER -- requirements
Module: divider_arbiter

---
 rtl/divider_arbiter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/divider_arbiter.sv
// Two-requester round-robin front end sharing one combinational array divider.
// Optional feature macro: DIVIDER_ARBITER_DBZ_CHECK_EN (divide-by-zero short-cut and flag).

module comb_array_divider #(
    parameter int XWIDTH = 8,
    parameter int YWIDTH = 4
) (
    input  logic [XWIDTH-1:0] x,
    input  logic [YWIDTH-1:0] y,
    output logic [XWIDTH-1:0] q,
    output logic [YWIDTH:0]   r
);
    // Restoring division, one stage per quotient bit, MSB first. A partial
    // remainder is always below y, so YWIDTH bits carry it between stages.
    for (genvar gi = 0; gi < XWIDTH; gi++) begin : g_stage
        logic [YWIDTH-1:0] rem_in;
        logic [YWIDTH-1:0] rem_out;
        logic [YWIDTH:0]   trial;
        logic              fits;

        if (gi == 0) begin : g_first
            assign rem_in = '0;
        end else begin : g_next
            assign rem_in = g_stage[gi-1].rem_out;
        end

        assign trial   = {rem_in, x[XWIDTH-1-gi]};
        assign fits    = (trial >= {1'b0, y});
        assign q[XWIDTH-1-gi] = fits;
        assign rem_out = fits ? YWIDTH'(trial - {1'b0, y}) : trial[YWIDTH-1:0];
    end

    assign r = {1'b0, g_stage[XWIDTH-1].rem_out};
endmodule

module divider_arbiter #(
    parameter int XWIDTH = 8,
    parameter int YWIDTH = 4,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [XWIDTH-1:0] req0_x,
    input  logic [YWIDTH-1:0] req0_y,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [XWIDTH-1:0] req1_x,
    input  logic [YWIDTH-1:0] req1_y,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [XWIDTH-1:0] rsp_q,
    output logic [YWIDTH:0]   rsp_r,
    output logic              rsp_dbz
);
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rr_q, rr_d;
    logic [XWIDTH-1:0] x_q, x_d;
    logic [YWIDTH-1:0] y_q, y_d;
    logic              id_q, id_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [XWIDTH-1:0] rsp_q_q, rsp_q_d;
    logic [YWIDTH:0]   rsp_r_q, rsp_r_d;
`ifdef DIVIDER_ARBITER_DBZ_CHECK_EN
    logic              rsp_dbz_q, rsp_dbz_d;
`endif

    logic              grant0, grant1;
    logic [XWIDTH-1:0] sel_x;
    logic [YWIDTH-1:0] sel_y;
    logic [XWIDTH-1:0] div_q;
    logic [YWIDTH:0]   div_r;

    comb_array_divider #(.XWIDTH(XWIDTH), .YWIDTH(YWIDTH)) u_div (
        .x (x_q),
        .y (y_q),
        .q (div_q),
        .r (div_r)
    );

    // rr_q set means requester 1 holds priority on a tie.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && state_q == ST_IDLE) begin
            if (req0_valid && (!req1_valid || !rr_q)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign sel_x = grant1 ? req1_x : req0_x;
    assign sel_y = grant1 ? req1_y : req0_y;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        x_d         = x_q;
        y_d         = y_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_q_d     = rsp_q_q;
        rsp_r_d     = rsp_r_q;
`ifdef DIVIDER_ARBITER_DBZ_CHECK_EN
        rsp_dbz_d   = rsp_dbz_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant0 || grant1) begin
                    x_d     = sel_x;
                    y_d     = sel_y;
                    id_d    = grant1;
                    rr_d    = !grant1;
                    state_d = ST_SETTLE;
                    cnt_d   = CNT_LOAD;
`ifdef DIVIDER_ARBITER_DBZ_CHECK_EN
                    if (sel_y == '0) begin
                        state_d     = ST_DONE;
                        cnt_d       = '0;
                        rsp_valid_d = 1'b1;
                        rsp_id_d    = grant1;
                        rsp_q_d     = '1;
                        rsp_r_d     = '0;
                        rsp_dbz_d   = 1'b1;
                    end
`endif
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d     = ST_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_q_d     = div_q;
                    rsp_r_d     = div_r;
`ifdef DIVIDER_ARBITER_DBZ_CHECK_EN
                    rsp_dbz_d   = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rr_q        <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_q_q     <= '0;
            rsp_r_q     <= '0;
`ifdef DIVIDER_ARBITER_DBZ_CHECK_EN
            rsp_dbz_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            x_q         <= x_d;
            y_q         <= y_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_q_q     <= rsp_q_d;
            rsp_r_q     <= rsp_r_d;
`ifdef DIVIDER_ARBITER_DBZ_CHECK_EN
            rsp_dbz_q   <= rsp_dbz_d;
`endif
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_q      = rsp_q_q;
    assign rsp_r      = rsp_r_q;
`ifdef DIVIDER_ARBITER_DBZ_CHECK_EN
    assign rsp_dbz    = rsp_dbz_q;
`else
    assign rsp_dbz    = 1'b0;
`endif
endmodule
